// File: rtl/output_classifier.sv
// Output layer of the MNIST pipeline: per-class signed MAC over one activation frame, bias add, sequential argmax.
// Define OVERFLOW_SAT_EN to make every accumulator add saturate instead of wrapping modulo 2^ACCW.
module output_classifier #(
  parameter int N_HIDDEN = 16,
  parameter int N_CLASS  = 10,
  parameter int AW       = 16,
  parameter int WW       = 9,
  parameter int ACCW     = 24,
  parameter int CW       = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CLASS*N_HIDDEN*WW-1:0]  weights,
  input  logic [N_CLASS*WW-1:0]           biases,
  input  logic [AW-1:0]                   in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [CW-1:0]                   class_out,
  output logic [ACCW-1:0]                 score_out,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int BW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
`ifdef OVERFLOW_SAT_EN
  localparam int PW = AW + WW + 1;
  localparam int TW = ((PW > ACCW) ? PW : ACCW) + 1;
`else
  localparam int TW = ACCW;
`endif

  typedef enum logic [1:0] {RECV, BIAS, ARGMAX, DONE} state_t;

  state_t                 state;
  logic [BW-1:0]          beat;
  logic signed [ACCW-1:0] acc     [N_CLASS];
  logic signed [ACCW-1:0] acc_sum [N_CLASS];
  logic signed [ACCW-1:0] best;
  logic [CW-1:0]          best_idx;
  logic [CW-1:0]          scan;
  logic                   scan_done;
  logic                   accept;

  assign accept = in_valid && in_ready;

  // Terms are wide enough in saturating mode that the sum is exact before clamping.
  function automatic logic signed [ACCW-1:0] acc_add(input logic signed [ACCW-1:0] a,
                                                     input logic signed [TW-1:0] t);
`ifdef OVERFLOW_SAT_EN
    logic signed [TW:0] s;
    s = (TW+1)'(a) + (TW+1)'(t);
    if ((&s[TW:ACCW-1]) || !(|s[TW:ACCW-1]))
      return s[ACCW-1:0];
    else if (s[TW])
      return {1'b1, {(ACCW-1){1'b0}}};
    else
      return {1'b0, {(ACCW-1){1'b1}}};
`else
    return a + t;
`endif
  endfunction

  // One adder per class, shared between the MAC beats and the bias cycle.
  generate
    for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_class
      logic signed [WW-1:0] w;
      logic signed [WW-1:0] b;
      logic signed [TW-1:0] term;

      assign w = weights[(gi*N_HIDDEN + int'(beat))*WW +: WW];
      assign b = biases[gi*WW +: WW];

      always_comb begin
        term = TW'($signed({1'b0, in_data})) * TW'(w);
        if (state == BIAS)
          term = TW'(b);
      end

      assign acc_sum[gi] = acc_add(acc[gi], term);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RECV;
      beat      <= '0;
      for (int i = 0; i < N_CLASS; i++) acc[i] <= '0;
      best      <= '0;
      best_idx  <= '0;
      scan      <= '0;
      scan_done <= 1'b0;
      class_out <= '0;
      score_out <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          in_ready <= 1'b1;
          if (accept) begin
            for (int i = 0; i < N_CLASS; i++) acc[i] <= acc_sum[i];
            if (beat == BW'(N_HIDDEN-1)) begin
              beat     <= '0;
              state    <= BIAS;
              in_ready <= 1'b0;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        BIAS: begin
          for (int i = 0; i < N_CLASS; i++) acc[i] <= acc_sum[i];
          best      <= acc_sum[0];
          best_idx  <= '0;
          scan      <= CW'(1);
          scan_done <= 1'b0;
          state     <= ARGMAX;
        end
        ARGMAX: begin
          // Strict compare so ties keep the lower class index.
          if (!scan_done) begin
            if (acc[scan] > best) begin
              best     <= acc[scan];
              best_idx <= scan;
            end
            if (scan == CW'(N_CLASS-1))
              scan_done <= 1'b1;
            else
              scan <= scan + CW'(1);
          end else begin
            class_out <= best_idx;
            score_out <= best;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int i = 0; i < N_CLASS; i++) acc[i] <= '0;
            in_ready  <= 1'b1;
            state     <= RECV;
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_output_classifier.sv
// Scoreboard bench for output_classifier: a frame-level reference model pushes expected results, a monitor pops them.
module tb_output_classifier;

  localparam int NH   = 16;
  localparam int NC   = 10;
  localparam int AW   = 16;
  localparam int WW   = 9;
  localparam int ACCW = 24;
  localparam int CW   = 4;
  localparam longint MODV = longint'(1) << ACCW;
  localparam longint MAXS = (longint'(1) << (ACCW-1)) - 1;
  localparam longint MINS = -(longint'(1) << (ACCW-1));

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NC*NH*WW-1:0]     weights;
  logic [NC*WW-1:0]        biases;
  logic [AW-1:0]           in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [CW-1:0]           class_out;
  logic [ACCW-1:0]         score_out;
  logic                    out_valid;
  logic                    out_ready;

  output_classifier dut (
    .clk(clk), .rst(rst), .weights(weights), .biases(biases),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .class_out(class_out), .score_out(score_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int cls; longint sc; } exp_t;
  exp_t sb[$];

  int act [NH];
  int w   [NC][NH];
  int b   [NC];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_accept = 0;
  int hold_req = 0;
  bit post_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: one add at a time, either wrapping or clamping to the score range.
  function automatic longint madd(input longint s, input longint t);
    longint r;
    r = s + t;
`ifdef OVERFLOW_SAT_EN
    if (r > MAXS) r = MAXS;
    if (r < MINS) r = MINS;
`else
    r = r % MODV;
    if (r < 0) r += MODV;
    if (r > MAXS) r -= MODV;
`endif
    return r;
  endfunction

  task automatic push_expected();
    exp_t e;
    longint s;
    e.cls = 0;
    e.sc  = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int k = 0; k < NH; k++) s = madd(s, longint'(act[k]) * longint'(w[c][k]));
      s = madd(s, longint'(b[c]));
      if (c == 0 || s > e.sc) begin
        e.cls = c;
        e.sc  = s;
      end
    end
    sb.push_back(e);
  endtask

  task automatic pack();
    for (int c = 0; c < NC; c++) begin
      biases[c*WW +: WW] = WW'(b[c]);
      for (int k = 0; k < NH; k++) weights[(c*NH+k)*WW +: WW] = WW'(w[c][k]);
    end
  endtask

  task automatic zero_all();
    for (int c = 0; c < NC; c++) begin
      b[c] = 0;
      for (int k = 0; k < NH; k++) w[c][k] = 0;
    end
    for (int k = 0; k < NH; k++) act[k] = 0;
  endtask

  task automatic randomize_all();
    for (int c = 0; c < NC; c++) begin
      b[c] = int'($urandom_range(0, 511)) - 256;
      for (int k = 0; k < NH; k++) w[c][k] = int'($urandom_range(0, 511)) - 256;
    end
    for (int k = 0; k < NH; k++)
      act[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535));
  endtask

  // gmode: 0 back-to-back, 1 valid toggles every cycle, 2 random gaps. Returns 0 on a stalled beat.
  task automatic send_beats(input int gmode, input int nbeats, output bit ok);
    int t;
    ok = 1;
    for (int k = 0; k < nbeats; k++) begin
      in_data  = AW'(act[k]);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        ok = 0;
        return;
      end
      @(negedge clk);
      last_accept = cyc;
      in_valid = 1'b0;
      in_data  = AW'($urandom);
      if (gmode == 1) @(negedge clk);
      else if (gmode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid || post_chk) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      chk("drain_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input int gmode, input int hold);
    bit ok;
    pack();
    hold_req = hold;
    send_beats(gmode, NH, ok);
    if (ok) push_expected();
    drain();
  endtask

  // Monitor: owns out_ready, checks latency, stability under backpressure and the handshake.
  initial begin
    bit   seen;
    int   hold_cnt;
    logic [CW-1:0]   first_cls;
    logic [ACCW-1:0] first_sc;
    exp_t e;
    seen = 0;
    hold_cnt = 0;
    first_cls = '0;
    first_sc = '0;
    forever begin
      @(negedge clk);
      if (post_chk) begin
        chk("valid_drop", longint'(out_valid), 0);
        chk("in_ready_after", longint'(in_ready), 1);
        chk("class_kept", longint'(class_out), longint'(first_cls));
        out_ready = 1'b0;
        post_chk = 0;
      end else if (out_valid && !rst) begin
        if (!seen) begin
          seen = 1;
          hold_cnt = 0;
          first_cls = class_out;
          first_sc = score_out;
          chk("latency", longint'(cyc - last_accept), NC + 1);
        end else begin
          chk("stable_class", longint'(class_out), longint'(first_cls));
          chk("stable_score", longint'($signed(score_out)), longint'($signed(first_sc)));
        end
        chk("in_ready_busy", longint'(in_ready), 0);
        if (hold_cnt >= hold_req) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("result: class=%0d score=%0d (want class=%0d score=%0d)",
                     class_out, $signed(score_out), e.cls, e.sc);
            chk("class_out", longint'(class_out), longint'(e.cls));
            chk("score_out", longint'($signed(score_out)), e.sc);
          end
          out_ready = 1'b1;
          post_chk = 1;
          seen = 0;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    zero_all();
    pack();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_class", longint'(class_out), 0);
    chk("rst_score", longint'(score_out), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_post_rst", longint'(in_ready), 1);

    // Bias only
    zero_all();
    b[7] = 5;
    run_frame(0, 0);

    // Tie: every class scores 1600, lowest index wins
    zero_all();
    for (int c = 0; c < NC; c++) for (int k = 0; k < NH; k++) w[c][k] = 1;
    for (int k = 0; k < NH; k++) act[k] = 100;
    run_frame(0, 0);

    // Single path
    zero_all();
    w[4][0] = 255;
    w[9][15] = -256;
    act[0] = 1000;
    act[15] = 1000;
    run_frame(0, 1);

    // Backpressure with toggled valid
    randomize_all();
    run_frame(1, 20);

    // Overflow
    zero_all();
    for (int k = 0; k < NH; k++) begin
      w[2][k] = 255;
      act[k] = 65535;
    end
    run_frame(0, 0);

    // Reset mid-frame, then the bias-only frame again
    randomize_all();
    pack();
    send_beats(0, 8, ok);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    zero_all();
    b[7] = 5;
    run_frame(0, 0);

    // Random frames
    for (int i = 0; i < 20; i++) begin
      randomize_all();
      run_frame(2, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_classifier.md
Name: output_classifier

Overview:
- Consumer side of the hidden-layer activation interface: accepts a frame of N_HIDDEN unsigned ReLU activations over a valid/ready stream.
- Performs a signed multiply-accumulate per output class, adds a per-class bias, then runs a sequential argmax.
- Presents the winning digit class and its score on a valid/ready output.
- Sits between the hidden-node array and the result/display logic of the MNIST pipeline.

Parameters:
- N_HIDDEN, 16, activations per frame (beats).
- N_CLASS, 10, number of output classes.
- AW, 16, activation width, unsigned.
- WW, 9, weight and bias width, two's complement.
- ACCW, 24, accumulator and score width, two's complement.
- CW, 4, class index width; must satisfy 2^CW >= N_CLASS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- weights  in  N_CLASS*N_HIDDEN*WW  weight for class c, beat k at bits [(c*N_HIDDEN+k)*WW +: WW]; held stable for the whole frame.
- biases  in  N_CLASS*WW  bias for class c at bits [c*WW +: WW].
- in_data  in  AW  activation value.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a beat this cycle.
- class_out  out  CW  argmax class index.
- score_out  out  ACCW  score of the winning class.
- out_valid  out  1  class_out and score_out are valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- States: RECV, BIAS, ARGMAX, DONE. Reset state is RECV.
- Reset clears beat counter, all accumulators, argmax registers, class_out=0, score_out=0, out_valid=0.
  - Reset asserted mid-frame discards the partial frame.
  - in_ready rises in the first cycle after rst deasserts.
- in_ready = (state==RECV). A beat is accepted on an edge where in_valid && in_ready.
- RECV, per accepted beat k:
  - For every c in parallel: acc[c] += sext(zext(in_data) * weights[c][k]).
  - Product is the signed (AW+WW+1)-bit result of the zero-extended activation times the signed weight.
  - The beat counter increments. When beat N_HIDDEN-1 is accepted, counter returns to 0 and next state is BIAS.
  - in_valid low leaves all state unchanged; the frame may have gaps of any length.
- BIAS, one cycle:
  - acc[c] += sext(biases[c]) for all c; init best_idx=0, best=acc[0]+bias[0], scan index=1.
  - Next state is ARGMAX.
- ARGMAX, one class per cycle, for c = 1..N_CLASS-1:
  - If acc[c] > best (strict, signed), update best and best_idx.
  - Ties keep the lower index.
  - Enters DONE after class N_CLASS-1 has been compared.
- Entering DONE: class_out=best_idx, score_out=best, out_valid=1.
  - out_valid rises exactly N_CLASS+1 edges after the edge that accepted the final beat: 11 for defaults.
- DONE:
  - Outputs hold stable while out_ready is low; in_ready stays 0.
  - On an edge with out_ready=1: out_valid=0, accumulators cleared, state RECV.
  - in_ready is high the next cycle; class_out and score_out keep their last values.
- Arithmetic wraps modulo 2^ACCW unless OVERFLOW_SAT_EN is defined.
- Weights and biases are sampled combinationally in RECV/BIAS. Changing them mid-frame is a usage error with undefined result.

Optional Feature:
- OVERFLOW_SAT_EN defined: every accumulator add (MAC and bias) saturates to [-2^(ACCW-1), 2^(ACCW-1)-1].
- OVERFLOW_SAT_EN undefined: adds wrap modulo 2^ACCW, with no extra logic.

Test Plan:
- Bias only:
  - Stimulus: all activations 0, all biases 0 except bias[7]=+5, then one frame.
  - Response: class_out=7, score_out=5, out_valid exactly 11 edges after the last accept.
- Tie:
  - Stimulus: all weights +1, all activations 100, biases 0.
  - Response: all scores 1600; class_out=0, score_out=1600.
- Single path:
  - Stimulus: weights 0 except w[4][0]=255 and w[9][15]=-256; act[0]=1000, act[15]=1000, others 0; biases 0.
  - Response: class_out=4, score_out=255000. Class 9 acc=-256000; remaining classes score 0.
- Backpressure:
  - Stimulus: in_valid toggled 1/0 every cycle during the frame; hold out_ready=0 for 20 cycles after out_valid.
  - Response: result identical to the gap-free frame; outputs stable; in_ready=0 until the out_ready handshake, then in_ready=1 next cycle.
- Overflow:
  - Stimulus: w[2][*]=255, all activations 65535, other weights and biases 0.
  - With OVERFLOW_SAT_EN: class_out=2, score_out=8388607.
  - Without: class 2 wraps to -1052656; class_out=0, score_out=0.
- Reset mid-frame:
  - Stimulus: assert rst after 8 beats, then send a fresh full frame matching test 1.
  - Response: out_valid=0 and in_ready=0 during rst; result matches test 1 with no residue from the aborted frame.
